// File: rtl/w5300_common_regs_responder.sv
// w5300_common_regs_responder
// Stands in for a W5300 on the common-register window (0x000-0x0FF) of the
// direct-address host bus. It answers the host sequencer's strobes, keeps
// register state with W5300 reset values, and models MR.RST soft reset and
// the interrupt pin.
//
// Parameters: RD_LAT (1-7) rd_n-fall-to-data cycles,
//             SOFT_RST_CYCLES (2-255) soft reset duration.
// Ports:
//   clk, rst           clock, async active-high reset
//   addr[9:0]          byte offset (bit 0 ignored, 16-bit access)
//   data_in[15:0]      write data
//   data_out[15:0]     read data, data_oe marks it valid
//   cs_n, rd_n, wr_n   active-low bus strobes, synchronous to clk
//   ir_set[3:0]        one-cycle pulses setting IR[15:12]
//   s0_int             level mirrored into IR[0]
//   int_n              active-low interrupt
//   busy               soft reset in progress
//   cfg_err            sticky configuration error
// Build option: define W5300_RESP_CFG_CHECK_EN to include the configuration
// checker; otherwise cfg_err is tied low.
//
// state      | meaning
// IDLE       | no read in progress
// READ_WAIT  | rd_n fall seen, latency down-counter running
// READ_DRIVE | data_out valid, data_oe high until rd_n/cs_n release
module w5300_common_regs_responder #(
  parameter int RD_LAT          = 2,
  parameter int SOFT_RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [3:0]  ir_set,
  input  logic        s0_int,
  output logic        int_n,
  output logic        busy,
  output logic        cfg_err
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE} state_t;

  typedef struct packed {
    logic [15:0] mr;
    logic [15:0] imr;
    logic [15:0] shar0;
    logic [15:0] shar1;
    logic [15:0] shar2;
    logic [15:0] gar0;
    logic [15:0] gar1;
    logic [15:0] subr0;
    logic [15:0] subr1;
    logic [15:0] sipr0;
    logic [15:0] sipr1;
    logic [15:0] rtr;
    logic [7:0]  rcr;
    logic [15:0] tms;
    logic [15:0] rms;
    logic [15:0] mtyper;
    logic [3:0]  ir_hi;
  } rf_t;

  localparam rf_t RF_RST = '{mr: 16'h3800, imr: 16'h0000, shar0: 16'h0000,
                             shar1: 16'h0000, shar2: 16'h0000, gar0: 16'h0000,
                             gar1: 16'h0000, subr0: 16'h0000, subr1: 16'h0000,
                             sipr0: 16'h0000, sipr1: 16'h0000, rtr: 16'h07D0,
                             rcr: 8'h08, tms: 16'h0808, rms: 16'h0808,
                             mtyper: 16'h00FF, ir_hi: 4'h0};
  localparam logic [15:0] MR_SRST = 16'h3880;
  localparam logic [15:0] IDR_VAL = 16'h5300;

  state_t      state, state_nx;
  rf_t         rf;
  logic        ir0;
  logic        cs_q, rd_q, wr_q;
  logic [9:1]  addr_q;
  logic [15:0] din_q;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  srst_cnt;
  logic [15:0] rdata, dout_nx;
  logic        doe_nx;
  logic        in_win, commit, srst_go, rd_fall;
  logic [6:0]  word;
  logic [3:0]  ir_clr;
  logic        unused_addr0;

  assign unused_addr0 = addr[0];

  // Bus sampling; previous-cycle samples define strobe edges and write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      cs_q   <= cs_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      addr_q <= addr[9:1];
      din_q  <= data_in;
    end
  end

  assign in_win  = (addr_q[9:8] == 2'b00);
  assign word    = addr_q[7:1];
  // rd_q low at the wr_n rise means rd_n and wr_n overlapped: no commit.
  assign commit  = ~wr_q & wr_n & ~cs_q & rd_q & ~busy;
  assign srst_go = commit & in_win & (word == 7'd0) & din_q[7];
  assign ir_clr  = (commit && in_win && word == 7'd1) ? din_q[15:12] : 4'h0;
  assign rd_fall = rd_q & ~rd_n & ~cs_n & wr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf       <= RF_RST;
      ir0      <= 1'b0;
      int_n    <= 1'b1;
      busy     <= 1'b0;
      srst_cnt <= '0;
    end else begin
      rf.ir_hi <= (rf.ir_hi & ~ir_clr) | ir_set;
      ir0      <= s0_int;
      int_n    <= ~|({rf.ir_hi, ir0} & {rf.imr[15:12], rf.imr[0]});
      if (busy) begin
        if (srst_cnt == 8'd0) begin
          busy     <= 1'b0;
          rf.mr[7] <= 1'b0;
        end else begin
          srst_cnt <= srst_cnt - 8'd1;
        end
      end
      if (srst_go) begin
        rf       <= RF_RST;
        rf.mr    <= MR_SRST;
        busy     <= 1'b1;
        srst_cnt <= 8'(SOFT_RST_CYCLES - 1);
      end else if (commit && in_win) begin
        case (word)
          7'd0:  rf.mr     <= din_q;
          7'd2:  rf.imr    <= din_q;
          7'd4:  rf.shar0  <= din_q;
          7'd5:  rf.shar1  <= din_q;
          7'd6:  rf.shar2  <= din_q;
          7'd8:  rf.gar0   <= din_q;
          7'd9:  rf.gar1   <= din_q;
          7'd10: rf.subr0  <= din_q;
          7'd11: rf.subr1  <= din_q;
          7'd12: rf.sipr0  <= din_q;
          7'd13: rf.sipr1  <= din_q;
          7'd14: rf.rtr    <= din_q;
          7'd15: rf.rcr    <= din_q[7:0];
          7'd16: rf.tms    <= din_q;
          7'd20: rf.rms    <= din_q;
          7'd24: rf.mtyper <= din_q;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (word)
        7'd0:   rdata = rf.mr;
        7'd1:   rdata = {rf.ir_hi, 11'd0, ir0};
        7'd2:   rdata = rf.imr;
        7'd4:   rdata = rf.shar0;
        7'd5:   rdata = rf.shar1;
        7'd6:   rdata = rf.shar2;
        7'd8:   rdata = rf.gar0;
        7'd9:   rdata = rf.gar1;
        7'd10:  rdata = rf.subr0;
        7'd11:  rdata = rf.subr1;
        7'd12:  rdata = rf.sipr0;
        7'd13:  rdata = rf.sipr1;
        7'd14:  rdata = rf.rtr;
        7'd15:  rdata = {8'h00, rf.rcr};
        7'd16:  rdata = rf.tms;
        7'd20:  rdata = rf.rms;
        7'd24:  rdata = rf.mtyper;
        7'd127: rdata = IDR_VAL;
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      data_out <= dout_nx;
      data_oe  <= doe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dout_nx  = data_out;
    doe_nx   = data_oe;
    case (state)
      IDLE: begin
        if (rd_fall) begin
          state_nx = READ_WAIT;
          cnt_nx   = 3'(RD_LAT - 1);
        end
      end
      READ_WAIT: begin
        if (rd_n || cs_n) begin
          state_nx = IDLE;
        end else if (cnt == 3'd0) begin
          state_nx = READ_DRIVE;
          dout_nx  = busy ? 16'h0000 : rdata;
          doe_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      READ_DRIVE: begin
        if (rd_n || cs_n) begin
          state_nx = IDLE;
          dout_nx  = '0;
          doe_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef W5300_RESP_CFG_CHECK_EN
  logic cfg_bad;

  always_comb begin
    cfg_bad = 1'b0;
    if (!in_win) begin
      cfg_bad = 1'b1;
    end else begin
      case (word)
        7'd0:  cfg_bad = ~din_q[15];
        7'd1, 7'd2, 7'd4, 7'd5, 7'd6, 7'd8, 7'd9, 7'd10, 7'd11,
        7'd12, 7'd13, 7'd14, 7'd15, 7'd24: cfg_bad = 1'b0;
        7'd16, 7'd20: cfg_bad = (din_q[15:8] > 8'd64) || (din_q[7:0] > 8'd64);
        default: cfg_bad = 1'b1;
      endcase
    end
  end

  // A soft-reset write clears the flag, but its own error still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if (commit) begin
      cfg_err <= (cfg_err & ~srst_go) | cfg_bad;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

endmodule
